// File: rtl/inst_mem.sv
// rtl/inst_mem.sv - instruction memory with combinational fetch port and byte-serial loader
// The fetch port returns NOP while a load is in progress.
module inst_mem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_dout_o,
  input  logic        ld_start_i,
  input  logic [31:0] ld_base_i,
  input  logic [15:0] ld_len_i,
  input  logic [7:0]  ld_byte_i,
  input  logic        ld_valid_i,
  output logic        ld_ready_o,
  output logic        ld_busy_o,
  output logic        ld_done_o,
  output logic        ld_err_o
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] DEPTH33 = 33'(DEPTH_WORDS);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t      state, state_nxt;
  logic [31:0] mem [DEPTH_WORDS];
  logic [AW-1:0] ptr;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [23:0] shreg;
  logic        done_q, err_q;

  logic        start_req, aligned, in_range;
  logic        start_ok, start_zero, start_bad;
  logic        accept, word_end, last_byte;
  logic [32:0] span;
  logic [31:0] word;

  // Span is computed at 33 bits so a large base plus length cannot wrap into range.
  assign span       = {3'b000, ld_base_i[31:2]} + {17'd0, ld_len_i};
  assign aligned    = (ld_base_i[1:0] == 2'b00);
  assign in_range   = (span <= DEPTH33);
  assign start_req  = (state == IDLE) && ld_start_i;
  assign start_ok   = start_req && aligned && in_range && (ld_len_i != 16'd0);
  assign start_zero = start_req && aligned && in_range && (ld_len_i == 16'd0);
  assign start_bad  = start_req && !(aligned && in_range);

  assign accept    = (state == LOAD) && ld_valid_i;
  assign word_end  = accept && (byte_cnt == 2'd3);
  assign last_byte = word_end && (word_cnt == 16'd1);
  assign word      = {ld_byte_i, shreg};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = LOAD;
      LOAD:    if (last_byte) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_ready_o = 1'b0;
    ld_busy_o  = 1'b0;
    if (state == LOAD) begin
      ld_ready_o = 1'b1;
      ld_busy_o  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr      <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= last_byte | start_zero;
      err_q  <= start_bad;
      if (start_ok) begin
        ptr      <= ld_base_i[AW+1:2];
        word_cnt <= ld_len_i;
        byte_cnt <= '0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    shreg[7:0]   <= ld_byte_i;
          2'd1:    shreg[15:8]  <= ld_byte_i;
          2'd2:    shreg[23:16] <= ld_byte_i;
          default: begin
            ptr      <= ptr + AW'(1);
            word_cnt <= word_cnt - 16'd1;
          end
        endcase
      end
    end
  end

  // Storage is deliberately not reset; words written before an aborted load survive.
  always_ff @(posedge clk_i) begin
    if (word_end) mem[ptr] <= word;
  end

  always_comb begin
    im_dout_o = NOP_INST;
    if (!ld_busy_o && (im_addr_i[1:0] == 2'b00) &&
        ({1'b0, im_addr_i[31:2]} < 31'(DEPTH_WORDS)))
      im_dout_o = mem[im_addr_i[AW+1:2]];
  end

  assign ld_done_o = done_q;
  assign ld_err_o  = err_q;

endmodule
